// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared constants, FSM state type and ALU opcodes for the BIST controller
//
// Purpose : single source for vector count, select width and opcode values so the
//           controller, sequencer and ALU agree on them.
// Ports   : none (package)
package bist_pkg;

    localparam int unsigned SEL_W         = 4;
    localparam int unsigned NUM_OPS       = 2 ** SEL_W;
    localparam int unsigned VECTORS       = 256;
    localparam int unsigned ADDR_W        = $clog2(VECTORS);
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CORE_RST,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } state_e;

    // ALU_Sel encodings shared with the ALU in the BIST core.
    localparam logic [SEL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [SEL_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [SEL_W-1:0] ALU_MUL  = 4'd2;
    localparam logic [SEL_W-1:0] ALU_DIV  = 4'd3;
    localparam logic [SEL_W-1:0] ALU_SHL  = 4'd4;
    localparam logic [SEL_W-1:0] ALU_SHR  = 4'd5;
    localparam logic [SEL_W-1:0] ALU_ROL  = 4'd6;
    localparam logic [SEL_W-1:0] ALU_ROR  = 4'd7;
    localparam logic [SEL_W-1:0] ALU_AND  = 4'd8;
    localparam logic [SEL_W-1:0] ALU_OR   = 4'd9;
    localparam logic [SEL_W-1:0] ALU_XOR  = 4'd10;
    localparam logic [SEL_W-1:0] ALU_NOR  = 4'd11;
    localparam logic [SEL_W-1:0] ALU_NAND = 4'd12;
    localparam logic [SEL_W-1:0] ALU_XNOR = 4'd13;
    localparam logic [SEL_W-1:0] ALU_GT   = 4'd14;
    localparam logic [SEL_W-1:0] ALU_EQ   = 4'd15;

endpackage

// File: rtl/bist_op_sequencer.sv
// rtl/bist_op_sequencer.sv - combinational search for the next enabled ALU operation
//
// Purpose : given an enable mask and the current select, return the next enabled
//           operation above it (or the lowest enabled one when starting a run).
// Ports   : en_mask_i    - operations eligible for testing
//           cur_sel_i    - operation currently driven to the core
//           from_start_i - 1: search from index 0 inclusive; 0: strictly above cur_sel_i
//           next_sel_o   - selected operation (0 when none found)
//           none_left_o  - no qualifying operation exists
module bist_op_sequencer
    import bist_pkg::*;
(
    input  logic [NUM_OPS-1:0] en_mask_i,
    input  logic [SEL_W-1:0]   cur_sel_i,
    input  logic               from_start_i,
    output logic [SEL_W-1:0]   next_sel_o,
    output logic               none_left_o
);

    // Scanning downward lets the last hit win, which is the lowest qualifying index.
    always_comb begin
        next_sel_o  = '0;
        none_left_o = 1'b1;
        for (int i = int'(NUM_OPS) - 1; i >= 0; i--) begin
            if (en_mask_i[i] && (from_start_i || (i > int'(cur_sel_i)))) begin
                next_sel_o  = SEL_W'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bist_ctrl_analyzer.sv
// rtl/bist_ctrl_analyzer.sv - BIST run controller and response analyser
//
// Purpose : steps the core's ALU select through every enabled operation, pulses the
//           core reset before each one, samples the comparator match flag over one
//           full vector sweep and accumulates the pass/fail results.
// Ports   : clk, reset          - clock, asynchronous active-high reset
//           start, abort        - run request pulse / level abort (abort wins)
//           op_enable           - operations to test, latched on an accepted start
//           match_i             - core comparator result for the current vector
//           core_reset_o        - reset to the core generators and address counter
//           alu_sel_o           - operation driven to the core
//           busy, done, pass    - run status and verdict
//           fail_count          - saturating mismatch total
//           fail_op_mask        - per-operation failure flags
//           first_fail_op/addr/vld - location of the first mismatch
module bist_ctrl_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_OPS-1:0] op_enable,
    input  logic               match_i,
    output logic               core_reset_o,
    output logic [SEL_W-1:0]   alu_sel_o,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   fail_count,
    output logic [NUM_OPS-1:0] fail_op_mask,
    output logic [SEL_W-1:0]   first_fail_op,
    output logic [ADDR_W-1:0]  first_fail_addr,
    output logic               first_fail_vld
);

    state_e             state_q, state_d;
    logic [NUM_OPS-1:0] op_en_q;
    logic [SEL_W-1:0]   alu_sel_q;
    logic [ADDR_W-1:0]  vec_idx_q;
    logic [CNT_W-1:0]   fail_count_q;
    logic [NUM_OPS-1:0] fail_op_mask_q;
    logic [SEL_W-1:0]   first_fail_op_q;
    logic [ADDR_W-1:0]  first_fail_addr_q;
    logic               first_fail_vld_q;
    logic               pass_q;

    logic               idle_or_done;
    logic               last_vec;
    logic [SEL_W-1:0]   seq_next;
    logic               seq_none;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign last_vec     = (vec_idx_q == ADDR_W'(VECTORS - 1));

    // While waiting for a start the search must see the live enable inputs, since
    // the first operation is chosen in the same cycle the mask is latched.
    bist_op_sequencer u_seq (
        .en_mask_i    (idle_or_done ? op_enable : op_en_q),
        .cur_sel_i    (alu_sel_q),
        .from_start_i (idle_or_done),
        .next_sel_o   (seq_next),
        .none_left_o  (seq_none)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = seq_none ? ST_DONE : ST_CORE_RST;
                    end
                end
                ST_CORE_RST: state_d = ST_RUN;
                ST_RUN: begin
                    if (last_vec) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT:     state_d = seq_none ? ST_DONE : ST_CORE_RST;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        core_reset_o = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_IDLE:     core_reset_o = 1'b1;
            ST_CORE_RST: begin
                core_reset_o = 1'b1;
                busy         = 1'b1;
            end
            ST_RUN:      busy = 1'b1;
            ST_NEXT:     busy = 1'b1;
            ST_DONE:     done = 1'b1;
            default:     core_reset_o = 1'b1;
        endcase
    end

    // Result datapath. An abort freezes everything so partial results stay visible;
    // the select only moves when the FSM is about to enter CORE_RST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_en_q           <= '0;
            alu_sel_q         <= '0;
            vec_idx_q         <= '0;
            fail_count_q      <= '0;
            fail_op_mask_q    <= '0;
            first_fail_op_q   <= '0;
            first_fail_addr_q <= '0;
            first_fail_vld_q  <= 1'b0;
            pass_q            <= 1'b0;
        end else if (!abort) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_en_q           <= op_enable;
                        fail_count_q      <= '0;
                        fail_op_mask_q    <= '0;
                        first_fail_op_q   <= '0;
                        first_fail_addr_q <= '0;
                        first_fail_vld_q  <= 1'b0;
                        // An empty mask completes immediately and trivially passes.
                        pass_q            <= seq_none;
                        if (!seq_none) begin
                            alu_sel_q <= seq_next;
                        end
                    end
                end
                ST_CORE_RST: vec_idx_q <= '0;
                ST_RUN: begin
                    vec_idx_q <= vec_idx_q + ADDR_W'(1);
                    if (!match_i) begin
                        if (fail_count_q != {CNT_W{1'b1}}) begin
                            fail_count_q <= fail_count_q + CNT_W'(1);
                        end
                        fail_op_mask_q[alu_sel_q] <= 1'b1;
                        if (!first_fail_vld_q) begin
                            first_fail_op_q   <= alu_sel_q;
                            first_fail_addr_q <= vec_idx_q;
                            first_fail_vld_q  <= 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (!seq_none) begin
                        alu_sel_q <= seq_next;
                    end else begin
                        pass_q <= (fail_count_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_sel_o       = alu_sel_q;
    assign pass            = pass_q;
    assign fail_count      = fail_count_q;
    assign fail_op_mask    = fail_op_mask_q;
    assign first_fail_op   = first_fail_op_q;
    assign first_fail_addr = first_fail_addr_q;
    assign first_fail_vld  = first_fail_vld_q;

endmodule

// File: tb/tb_bist_ctrl_analyzer.sv
// tb/tb_bist_ctrl_analyzer.sv - self-checking bench for bist_ctrl_analyzer
module tb_bist_ctrl_analyzer;

    localparam int PER = 258;   // CORE_RST + 256 RUN cycles + NEXT

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        match_i = 1'b0;
    logic [15:0] op_enable = '0;

    logic        core_reset_o, busy, done, pass, first_fail_vld;
    logic [3:0]  alu_sel_o, first_fail_op;
    logic [15:0] fail_count, fail_op_mask;
    logic [7:0]  first_fail_addr;

    logic        d8_core_reset, d8_busy, d8_done, d8_pass, d8_ff_vld;
    logic [3:0]  d8_alu_sel, d8_ff_op;
    logic [7:0]  d8_fail_count, d8_ff_addr;
    logic [15:0] d8_fail_mask;

    always #5 clk = ~clk;

    bist_ctrl_analyzer #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op_enable(op_enable),
        .match_i(match_i), .core_reset_o(core_reset_o), .alu_sel_o(alu_sel_o),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .fail_op_mask(fail_op_mask), .first_fail_op(first_fail_op),
        .first_fail_addr(first_fail_addr), .first_fail_vld(first_fail_vld)
    );

    bist_ctrl_analyzer #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op_enable(op_enable),
        .match_i(match_i), .core_reset_o(d8_core_reset), .alu_sel_o(d8_alu_sel),
        .busy(d8_busy), .done(d8_done), .pass(d8_pass), .fail_count(d8_fail_count),
        .fail_op_mask(d8_fail_mask), .first_fail_op(d8_ff_op),
        .first_fail_addr(d8_ff_addr), .first_fail_vld(d8_ff_vld)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is a list of enabled ops, each occupying PER cycles.
    bit          m_active, m_done, m_pass, m_ff_vld, chk_en, all_fail;
    int          m_n, m_num, m_cnt, m_ff_op, m_ff_addr, m_sel;
    int          m_ops[16];
    logic [15:0] m_mask;
    int          mm_op[$];
    int          mm_vec[$];

    function automatic bit is_mm(input int op, input int vec);
        foreach (mm_op[k]) begin
            if (mm_op[k] == op && mm_vec[k] == vec) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_done = 0; m_pass = 0; m_cnt = 0; m_mask = '0;
            m_ff_vld = 0; m_ff_op = 0; m_ff_addr = 0; m_sel = 0; m_n = 0;
        end else if (abort) begin
            m_active = 0;
            m_done   = 0;
        end else if (m_active) begin
            int p;
            int j;
            p = m_n % PER;
            j = m_n / PER;
            if (p >= 1 && p <= 256 && !match_i) begin
                m_cnt++;
                m_mask[m_ops[j]] = 1'b1;
                if (!m_ff_vld) begin
                    m_ff_vld  = 1;
                    m_ff_op   = m_ops[j];
                    m_ff_addr = p - 1;
                end
            end
            m_n++;
            if (m_n == m_num * PER) begin
                m_active = 0;
                m_done   = 1;
                m_pass   = (m_cnt == 0);
            end else if (m_n % PER == 0) begin
                m_sel = m_ops[m_n / PER];
            end
        end else if (start) begin
            m_num = 0;
            for (int i = 0; i < 16; i++) begin
                if (op_enable[i]) begin
                    m_ops[m_num] = i;
                    m_num++;
                end
            end
            m_cnt = 0; m_mask = '0; m_ff_vld = 0; m_ff_op = 0; m_ff_addr = 0;
            m_done = 0; m_pass = 0;
            if (m_num == 0) begin
                m_done = 1;
                m_pass = 1;
            end else begin
                m_active = 1;
                m_n      = 0;
                m_sel    = m_ops[0];
            end
        end
    end

    // Core stand-in: reports a match only during the sweep; 0 elsewhere so stray sampling shows up.
    always @(negedge clk) begin
        int p;
        p = m_n % PER;
        if (m_active && p >= 1 && p <= 256)
            match_i = !(all_fail || is_mm(m_ops[m_n / PER], p - 1));
        else
            match_i = 1'b0;
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("busy", longint'(busy), longint'(m_active));
            chk("done", longint'(done), longint'(m_done));
            chk("core_reset", longint'(core_reset_o),
                longint'((!m_active && !m_done) || (m_active && (m_n % PER) == 0)));
            chk("alu_sel", longint'(alu_sel_o), longint'(m_sel));
            chk("fail_count", longint'(fail_count), longint'(m_cnt > 65535 ? 65535 : m_cnt));
            chk("fail_count_w8", longint'(d8_fail_count), longint'(m_cnt > 255 ? 255 : m_cnt));
            chk("fail_op_mask", longint'(fail_op_mask), longint'(m_mask));
            chk("first_fail_vld", longint'(first_fail_vld), longint'(m_ff_vld));
            if (m_ff_vld) begin
                chk("first_fail_op", longint'(first_fail_op), longint'(m_ff_op));
                chk("first_fail_addr", longint'(first_fail_addr), longint'(m_ff_addr));
            end
            if (m_done) chk("pass", longint'(pass), longint'(m_pass));
        end
    end

    task automatic do_start(input logic [15:0] en);
        op_enable = en;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        for (int it = 0; it < budget && !done; it++) begin
            if (busy) cyc++;
            @(negedge clk);
        end
        chk("done within budget", longint'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        chk_en = 1;
        repeat (3) @(negedge clk);
        chk("rst core_reset", longint'(core_reset_o), 1);
        chk("rst busy", longint'(busy), 0);
        chk("rst done", longint'(done), 0);
        chk("rst pass", longint'(pass), 0);
        chk("rst alu_sel", longint'(alu_sel_o), 0);
        chk("rst fail_count", longint'(fail_count), 0);
        chk("rst first_fail_vld", longint'(first_fail_vld), 0);
        reset = 1'b0;
        @(negedge clk);

        // All ops, every vector matches.
        do_start(16'hFFFF);
        wait_done(5000, cyc);
        chk("t1 busy cycles", cyc, 4128);
        chk("t1 pass", longint'(pass), 1);
        chk("t1 fail_count", longint'(fail_count), 0);
        chk("t1 mask", longint'(fail_op_mask), 0);
        chk("t1 ff_vld", longint'(first_fail_vld), 0);

        // Ops 0 and 2, single mismatch at op 2 vector 37; a start mid-run is ignored.
        mm_op.push_back(2); mm_vec.push_back(37);
        do_start(16'h0005);
        chk("t2 first sel", longint'(alu_sel_o), 0);
        repeat (10) @(negedge clk);
        op_enable = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (247) @(negedge clk);
        chk("t2 second core_reset", longint'(core_reset_o), 1);
        chk("t2 second sel", longint'(alu_sel_o), 2);
        wait_done(1000, cyc);
        chk("t2 fail_count", longint'(fail_count), 1);
        chk("t2 mask", longint'(fail_op_mask), 16'h0004);
        chk("t2 ff_op", longint'(first_fail_op), 2);
        chk("t2 ff_addr", longint'(first_fail_addr), 37);
        chk("t2 pass", longint'(pass), 0);
        mm_op.delete(); mm_vec.delete();

        // One op always failing, repeated runs without reset; narrow counter saturates.
        all_fail = 1;
        for (int r = 0; r < 3; r++) begin
            do_start(16'h0100);
            wait_done(600, cyc);
            chk("t3 busy cycles", cyc, 258);
            chk("t3 fail_count", longint'(fail_count), 256);
            chk("t3 fail_count_w8", longint'(d8_fail_count), 255);
            chk("t3 mask", longint'(fail_op_mask), 16'h0100);
            chk("t3 ff_op", longint'(first_fail_op), 8);
            chk("t3 ff_addr", longint'(first_fail_addr), 0);
        end
        all_fail = 0;

        // Empty enable mask.
        do_start(16'h0000);
        chk("t4 done", longint'(done), 1);
        chk("t4 pass", longint'(pass), 1);
        chk("t4 busy", longint'(busy), 0);
        chk("t4 core_reset", longint'(core_reset_o), 0);
        repeat (3) @(negedge clk);

        // Abort at vector 100 of op 3 (with a simultaneous start), then restart.
        mm_op.push_back(3); mm_vec.push_back(50);
        do_start(16'h0018);
        repeat (101) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("t5 busy", longint'(busy), 0);
        chk("t5 done", longint'(done), 0);
        chk("t5 core_reset", longint'(core_reset_o), 1);
        chk("t5 partial count", longint'(fail_count), 1);
        chk("t5 partial ff_addr", longint'(first_fail_addr), 50);
        do_start(16'h0018);
        chk("t5 restart sel", longint'(alu_sel_o), 3);
        chk("t5 restart count", longint'(fail_count), 0);
        chk("t5 restart ff_vld", longint'(first_fail_vld), 0);
        wait_done(1000, cyc);
        chk("t5 busy cycles", cyc, 516);
        chk("t5 mask", longint'(fail_op_mask), 16'h0008);
        mm_op.delete(); mm_vec.delete();

        // Asynchronous reset mid-run takes effect before the next clock edge.
        all_fail = 1;
        do_start(16'h0040);
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6 core_reset", longint'(core_reset_o), 1);
        chk("t6 busy", longint'(busy), 0);
        chk("t6 alu_sel", longint'(alu_sel_o), 0);
        chk("t6 fail_count", longint'(fail_count), 0);
        chk("t6 mask", longint'(fail_op_mask), 0);
        chk("t6 ff_vld", longint'(first_fail_vld), 0);
        @(negedge clk);
        reset = 1'b0;
        all_fail = 0;
        repeat (3) @(negedge clk);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
